// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the WM8731 DAC stream path.
//   frame_fmt_e    : serial framing, I2S (one BCLK MSB delay) or left-justified
//   frame_state_e  : frame sequencer states of the DAC stream engine
//   SYNC_STAGES    : synchroniser depth for the codec clocks
//   UNDERRUN_CNT_W : width of the saturating underrun counter
// ---------------------------------------------------------------------------
package audio_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } frame_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } frame_state_e;

  localparam int SYNC_STAGES    = 2;
  localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
// Synchronous FIFO holding PCM frames between the sound logic and the
// serialiser. Read data is presented combinationally from the head entry.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, wdata_i : write request and frame data
//   pop_i, rdata_o  : read request and head-of-queue frame
//   full_o, empty_o : occupancy flags
//   level_o         : number of stored frames (0..DEPTH)
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush, doPop;

  // Pointers carry one extra wrap bit, so their difference is the fill level
  assign level_o = wrPtr_q - rdPtr_q;
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));

  // A push while full is only taken when a pop frees the head slot the same cycle
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale entries unreachable
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/audio_i2s_dac_stream.sv
// ---------------------------------------------------------------------------
// audio_i2s_dac_stream
// DAC-side stream engine for the WM8731 in slave mode: buffers PCM frames in
// a FIFO and shifts them out MSB first on AUD_DACDAT, timed by the codec's
// BCLK / DACLRCK which are synchronised into clk_i.
// Ports:
//   clk_i, rst_ni              : system clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_ready_o : frame input handshake ([DATA_W-1:0] = left/mono)
//   lj_mode_i                  : 0 = I2S, 1 = left-justified (taken at frame start)
//   mute_i                     : send zeros while still draining (taken at frame start)
//   clr_underrun_i             : clears underrun flag and counter
//   aud_bclk_i, aud_daclrck_i  : codec bit clock and LR clock (low = left)
//   aud_dacdat_o               : serial DAC data
//   fill_level_o               : frames currently buffered
//   frame_tick_o               : one-cycle pulse per frame start
//   underrun_o, underrun_cnt_o : sticky underrun flag and saturating count
// ---------------------------------------------------------------------------
module audio_i2s_dac_stream
  import audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_CH*DATA_W-1:0]    s_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic                        lj_mode_i,
  input  logic                        mute_i,
  input  logic                        clr_underrun_i,
  input  logic                        aud_bclk_i,
  input  logic                        aud_daclrck_i,
  output logic                        aud_dacdat_o,
  output logic [$clog2(FIFO_DEPTH):0] fill_level_o,
  output logic                        frame_tick_o,
  output logic                        underrun_o,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt_o
);

  localparam int CNT_W = $clog2(SLOT_W + 1);

  logic [SYNC_STAGES:0]        bclkSync_q, lrckSync_q;
  logic                        bclkFall, lrckFall, lrckRise;
  frame_state_e                state_q, state_d;
  logic                        frameStart, halfStart;
  logic                        fifoFull, fifoEmpty, fifoPop, fifoPush;
  logic [NUM_CH*DATA_W-1:0]    fifoRdata;
  logic [DATA_W-1:0]           leftWord, rightWord, frameL, frameR, halfWord;
  logic [DATA_W-1:0]           holdR_q;
  frame_fmt_e                  fmt_q, fmtEff;
  logic [SLOT_W-1:0]           loadVec, shift_q;
  logic [CNT_W-1:0]            bitCnt_q;
  logic                        dacDat_q, frameTick_q, underrun_q, underrunEvt;
  logic [UNDERRUN_CNT_W-1:0]   underrunCnt_q;

  // Codec clocks are async; the top flop of each chain holds the previous
  // synchronised value for edge detection. Clearing to 0 means an LRCK that
  // is low at reset release produces no false falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclkSync_q <= '0;
      lrckSync_q <= '0;
    end else begin
      bclkSync_q <= {bclkSync_q[SYNC_STAGES-1:0], aud_bclk_i};
      lrckSync_q <= {lrckSync_q[SYNC_STAGES-1:0], aud_daclrck_i};
    end
  end

  assign bclkFall = bclkSync_q[SYNC_STAGES] & ~bclkSync_q[SYNC_STAGES-1];
  assign lrckFall = lrckSync_q[SYNC_STAGES] & ~lrckSync_q[SYNC_STAGES-1];
  assign lrckRise = ~lrckSync_q[SYNC_STAGES] & lrckSync_q[SYNC_STAGES-1];

  // Frame sequencer: IDLE waits for the first left half so output starts
  // frame-aligned; once aligned every LRCK edge reloads, even mid-half.
  always_comb begin
    state_d    = state_q;
    frameStart = 1'b0;
    halfStart  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lrckFall) begin
          state_d    = ST_LEFT;
          frameStart = 1'b1;
          halfStart  = 1'b1;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        if (lrckFall) begin
          state_d    = ST_LEFT;
          frameStart = 1'b1;
          halfStart  = 1'b1;
        end else if (lrckRise) begin
          state_d    = ST_RIGHT;
          halfStart  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_ready_o   = ~fifoFull;
  assign fifoPush    = s_valid_i & s_ready_o;
  assign fifoPop     = frameStart & ~fifoEmpty;
  assign underrunEvt = frameStart & fifoEmpty;

  audio_sample_fifo #(
    .WIDTH (NUM_CH * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifoPush),
    .wdata_i (s_data_i),
    .pop_i   (fifoPop),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fill_level_o)
  );

  assign leftWord = fifoRdata[DATA_W-1:0];
  if (NUM_CH == 2) begin : gStereo
    assign rightWord = fifoRdata[2*DATA_W-1:DATA_W];
  end else begin : gMono
    assign rightWord = leftWord;
  end

  // Underrun and mute both substitute silence; a muted frame is still consumed
  assign frameL   = (fifoPop && !mute_i) ? leftWord  : '0;
  assign frameR   = (fifoPop && !mute_i) ? rightWord : '0;
  assign halfWord = frameStart ? frameL : holdR_q;
  assign fmtEff   = frameStart ? (lj_mode_i ? FMT_LJ : FMT_I2S) : fmt_q;
  assign loadVec  = SLOT_W'(halfWord) << (SLOT_W - DATA_W);

  // Frame state, right-word holding register and per-frame format
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      holdR_q     <= '0;
      fmt_q       <= FMT_I2S;
      frameTick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frameTick_q <= frameStart;
      if (frameStart) begin
        holdR_q <= frameR;
        fmt_q   <= fmtEff;
      end
    end
  end

  // Shift-out datapath. LJ drives the MSB in the edge cycle itself; I2S
  // drives 0 there so the MSB lands one BCLK later. After SLOT_W bits the
  // line idles low until the next LRCK edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q  <= '0;
      bitCnt_q <= '0;
      dacDat_q <= 1'b0;
    end else if (halfStart) begin
      if (fmtEff == FMT_LJ) begin
        dacDat_q <= loadVec[SLOT_W-1];
        shift_q  <= loadVec << 1;
        bitCnt_q <= CNT_W'(1);
      end else begin
        dacDat_q <= 1'b0;
        shift_q  <= loadVec;
        bitCnt_q <= '0;
      end
    end else if (state_q != ST_IDLE && bclkFall) begin
      if (bitCnt_q < CNT_W'(SLOT_W)) begin
        dacDat_q <= shift_q[SLOT_W-1];
        shift_q  <= shift_q << 1;
        bitCnt_q <= bitCnt_q + 1'b1;
      end else begin
        dacDat_q <= 1'b0;
      end
    end
  end

  // Underrun accounting; a clear coincident with an underrun still counts it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_q    <= 1'b0;
      underrunCnt_q <= '0;
    end else if (clr_underrun_i) begin
      underrun_q    <= underrunEvt;
      underrunCnt_q <= underrunEvt ? UNDERRUN_CNT_W'(1) : '0;
    end else if (underrunEvt) begin
      underrun_q <= 1'b1;
      if (underrunCnt_q != '1) underrunCnt_q <= underrunCnt_q + 1'b1;
    end
  end

  assign aud_dacdat_o   = dacDat_q;
  assign frame_tick_o   = frameTick_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = underrunCnt_q;

endmodule

// File: tb/tb_audio_i2s_dac_stream.sv
// ---------------------------------------------------------------------------
// tb_audio_i2s_dac_stream
// Drives codec BCLK/LRCK, pushes frames and compares the serial stream, fill
// level and underrun state against a queue-based reference. A second, mono
// instance shares the codec clocks.
// ---------------------------------------------------------------------------
module tb_audio_i2s_dac_stream;

  localparam int DW    = 16;
  localparam int SW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [2*DW-1:0] sData = '0;
  logic          sValid = 1'b0;
  logic          sReady;
  logic          ljMode = 1'b0;
  logic          mute = 1'b0;
  logic          clrUnderrun = 1'b0;
  logic          bclk = 1'b1;
  logic          lrck = 1'b1;
  logic          dacDat, frameTick, underrun;
  logic [LW-1:0] fillLevel;
  logic [15:0]   underrunCnt;

  logic [DW-1:0] mData = '0;
  logic          mValid = 1'b0;
  logic          mMute = 1'b0;
  logic          mReady, mDac, mTick, mUnderrun;
  logic [LW-1:0] mFill;
  logic [15:0]   mUcnt;

  int checkCount = 0;
  int passCount  = 0;
  int tickCount  = 0;
  int frameCount = 0;

  logic [2*DW-1:0] modelQ[$];
  int              modelUcnt = 0;
  bit              modelUflag = 1'b0;
  logic [2*DW-1:0] expFrame = '0;
  bit              expLj = 1'b0;
  logic [31:0]     capS, capM, capLs, capRs, capLm, capRm;

  audio_i2s_dac_stream #(.DATA_W(DW), .SLOT_W(SW), .NUM_CH(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .s_data_i       (sData),
    .s_valid_i      (sValid),
    .s_ready_o      (sReady),
    .lj_mode_i      (ljMode),
    .mute_i         (mute),
    .clr_underrun_i (clrUnderrun),
    .aud_bclk_i     (bclk),
    .aud_daclrck_i  (lrck),
    .aud_dacdat_o   (dacDat),
    .fill_level_o   (fillLevel),
    .frame_tick_o   (frameTick),
    .underrun_o     (underrun),
    .underrun_cnt_o (underrunCnt)
  );

  audio_i2s_dac_stream #(.DATA_W(DW), .SLOT_W(SW), .NUM_CH(1), .FIFO_DEPTH(DEPTH)) dutMono (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .s_data_i       (mData),
    .s_valid_i      (mValid),
    .s_ready_o      (mReady),
    .lj_mode_i      (ljMode),
    .mute_i         (mMute),
    .clr_underrun_i (clrUnderrun),
    .aud_bclk_i     (bclk),
    .aud_daclrck_i  (lrck),
    .aud_dacdat_o   (mDac),
    .fill_level_o   (mFill),
    .frame_tick_o   (mTick),
    .underrun_o     (mUnderrun),
    .underrun_cnt_o (mUcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameTick) tickCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Expected bits of one half, index = order seen on BCLK rises after the LRCK edge
  function automatic logic [31:0] expHalf(input logic [DW-1:0] w, input bit lj);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < SW; i++) begin
      if (lj && i < DW) v[i] = w[DW-1-i];
      else if (!lj && i >= 1 && i <= DW) v[i] = w[DW-i];
    end
    return v;
  endfunction

  task automatic modelFrameStart();
    frameCount++;
    expLj = ljMode;
    if (modelQ.size() > 0) begin
      expFrame = modelQ.pop_front();
      if (mute) expFrame = '0;
    end else begin
      expFrame   = '0;
      modelUflag = 1'b1;
      if (modelUcnt < 65535) modelUcnt++;
    end
  endtask

  task automatic applyStimulus(input logic [2*DW-1:0] data);
    bit accept;
    @(posedge clk); #1;
    accept = (modelQ.size() < DEPTH);
    checkOutput("readyBeforePush", 32'(sReady), 32'(accept));
    sData  = data;
    sValid = 1'b1;
    @(posedge clk); #1;
    sValid = 1'b0;
    if (accept) modelQ.push_back(data);
  endtask

  task automatic applyMonoStimulus(input logic [DW-1:0] data);
    @(posedge clk); #1;
    mData  = data;
    mValid = 1'b1;
    @(posedge clk); #1;
    mValid = 1'b0;
  endtask

  task automatic pulseClear();
    @(posedge clk); #1;
    clrUnderrun = 1'b1;
    @(posedge clk); #1;
    clrUnderrun = 1'b0;
    modelUflag = 1'b0;
    modelUcnt  = 0;
  endtask

  // One LRCK half of SW BCLK periods; optionally asserts reset after bit resetAt
  task automatic runHalf(input bit side, input int resetAt);
    for (int b = 0; b < SW; b++) begin
      bclk = 1'b0;
      if (b == 0) lrck = side;
      #60;
      bclk = 1'b1;
      capS[b] = dacDat;
      capM[b] = mDac;
      if (b == resetAt) begin
        rstN = 1'b0;
        #1;
        checkOutput("resetDac", 32'(dacDat), 32'd0);
        checkOutput("resetFill", 32'(fillLevel), 32'd0);
        #59;
      end else begin
        #60;
      end
    end
    if (resetAt >= 0) rstN = 1'b1;
  endtask

  task automatic runFrame(input bit flipMid);
    @(negedge clk);
    modelFrameStart();
    runHalf(1'b0, -1);
    capLs = capS;
    capLm = capM;
    if (flipMid) begin
      ljMode = ~ljMode;
      mute   = ~mute;
    end
    runHalf(1'b1, -1);
    capRs = capS;
    capRm = capM;
  endtask

  task automatic checkFrame();
    checkOutput("leftBits", capLs, expHalf(expFrame[DW-1:0], expLj));
    checkOutput("rightBits", capRs, expHalf(expFrame[2*DW-1:DW], expLj));
    checkOutput("fill", 32'(fillLevel), 32'(modelQ.size()));
    checkOutput("ready", 32'(sReady), 32'(modelQ.size() < DEPTH));
    checkOutput("underrun", 32'(underrun), 32'(modelUflag));
    checkOutput("underrunCnt", 32'(underrunCnt), 32'(modelUcnt));
  endtask

  initial begin
    $display("[TB] audio_i2s_dac_stream bench start");
    #23;
    checkOutput("inResetDac", 32'(dacDat), 32'd0);
    checkOutput("inResetFill", 32'(fillLevel), 32'd0);
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstDac", 32'(dacDat), 32'd0);
    checkOutput("rstFill", 32'(fillLevel), 32'd0);
    checkOutput("rstReady", 32'(sReady), 32'd1);
    checkOutput("rstTick", 32'(frameTick), 32'd0);
    checkOutput("rstUnderrun", 32'(underrun), 32'd0);
    checkOutput("rstUnderrunCnt", 32'(underrunCnt), 32'd0);

    // Directed I2S then LJ frame with a known pattern
    applyStimulus({16'h8001, 16'hA5C3});
    runFrame(1'b0);
    checkFrame();
    ljMode = 1'b1;
    applyStimulus({16'h8001, 16'hA5C3});
    runFrame(1'b0);
    checkFrame();
    ljMode = 1'b0;

    // Fill to capacity with BCLK stopped, then hold a rejected 9th frame
    for (int k = 0; k < DEPTH; k++) applyStimulus($urandom);
    checkOutput("fillFull", 32'(fillLevel), 32'd8);
    checkOutput("readyFull", 32'(sReady), 32'd0);
    @(posedge clk); #1;
    sData  = $urandom;
    sValid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("fillHeld", 32'(fillLevel), 32'd8);
    sValid = 1'b0;
    runFrame(1'b0);
    checkFrame();
    checkOutput("fillAfterPop", 32'(fillLevel), 32'd7);
    checkOutput("readyAfterPop", 32'(sReady), 32'd1);

    // Randomised frames: random data, format, mute and mid-frame control flips
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) applyStimulus($urandom);
      ljMode = 1'($urandom_range(0, 1));
      mute   = ($urandom_range(0, 3) == 0);
      runFrame(1'($urandom_range(0, 1)));
      checkFrame();
    end

    // Drain, then underrun accounting
    mute   = 1'b0;
    ljMode = 1'b0;
    for (int g = 0; g < DEPTH + 1 && modelQ.size() > 0; g++) begin
      runFrame(1'b0);
      checkFrame();
    end
    pulseClear();
    checkOutput("clrUnderrun", 32'(underrun), 32'd0);
    checkOutput("clrUnderrunCnt", 32'(underrunCnt), 32'd0);
    for (int g = 0; g < 3; g++) begin
      runFrame(1'b0);
      checkFrame();
    end
    checkOutput("underrunAfter3", 32'(underrun), 32'd1);
    checkOutput("underrunCntAfter3", 32'(underrunCnt), 32'd3);
    pulseClear();
    checkOutput("clr2Underrun", 32'(underrun), 32'd0);
    checkOutput("clr2UnderrunCnt", 32'(underrunCnt), 32'd0);
    runFrame(1'b0);
    checkFrame();
    checkOutput("underrunCntRestart", 32'(underrunCnt), 32'd1);

    // Mono instance: one word on both halves, then a muted frame still drains
    applyMonoStimulus(16'h1234);
    checkOutput("monoFill1", 32'(mFill), 32'd1);
    runFrame(1'b0);
    checkFrame();
    checkOutput("monoLeft", capLm, expHalf(16'h1234, 1'b0));
    checkOutput("monoRight", capRm, expHalf(16'h1234, 1'b0));
    checkOutput("monoFill0", 32'(mFill), 32'd0);
    applyMonoStimulus(16'h5678);
    mMute = 1'b1;
    checkOutput("monoFillPreMute", 32'(mFill), 32'd1);
    runFrame(1'b0);
    checkFrame();
    checkOutput("monoMuteLeft", capLm, 32'd0);
    checkOutput("monoMuteRight", capRm, 32'd0);
    checkOutput("monoMuteFill", 32'(mFill), 32'd0);
    mMute = 1'b0;

    // Reset in the middle of a left half, then realignment
    applyStimulus({16'h0F0F, 16'hFFFF});
    @(negedge clk);
    modelFrameStart();
    runHalf(1'b0, 5);
    modelQ.delete();
    modelUflag = 1'b0;
    modelUcnt  = 0;
    checkOutput("resetHalfBits", capS, 32'h0000_003E);
    checkOutput("postResetUnderrun", 32'(underrun), 32'd0);
    checkOutput("postResetUnderrunCnt", 32'(underrunCnt), 32'd0);
    applyStimulus({16'h1357, 16'h2468});
    @(negedge clk);
    runHalf(1'b1, -1);
    checkOutput("ignoredRiseBits", capS, 32'd0);
    checkOutput("ignoredRiseFill", 32'(fillLevel), 32'd1);
    runFrame(1'b0);
    checkFrame();

    checkOutput("frameTicks", 32'(tickCount), 32'(frameCount));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
